// File: rtl/weight_fetch_sequencer_if.sv
// Weight fetch channel: layer-controller request, ROM port,
// and the valid/ready word stream to the PE-array loader.
interface weight_fetch_sequencer_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_W    = 20,
    parameter int LEN_W     = 16
);
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [LEN_W-1:0]     length;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    rom_addr;
    logic [DATA_SIZE-1:0] rom_data;
    logic [DATA_SIZE-1:0] w_data;
    logic                 w_valid;
    logic                 w_ready;

    modport master (
        input  start, base_addr, length, rom_data, w_ready,
        output busy, done, rom_addr, w_data, w_valid
    );

    modport slave (
        output start, base_addr, length, rom_data, w_ready,
        input  busy, done, rom_addr, w_data, w_valid
    );
endinterface

// File: rtl/weight_fetch_sequencer.sv
// Streams a weight tile out of block ROM through a credit-limited
// skid FIFO that absorbs the fixed ROM read latency.
module weight_fetch_sequencer #(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_W      = 20,
    parameter int LEN_W       = 16,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input logic clk,
    input logic reset,
    weight_fetch_sequencer_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0]      rom_addr_q;
    logic [LEN_W-1:0]       length_q;
    logic [LEN_W-1:0]       issued;
    logic [LEN_W-1:0]       popped;
    logic [CW-1:0]          credits;
    logic [CW-1:0]          count;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [ROM_LATENCY-1:0] inflight;
    logic [DATA_SIZE-1:0]   mem [FIFO_DEPTH];

    logic accept;
    logic issue;
    logic pop;
    logic push;
    logic last_pop;
    logic fifo_nonempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = count != '0;
    assign accept   = (state == IDLE) && bus.start;
    assign issue    = (state == RUN) && (issued != length_q)
                      && (credits < CW'(FIFO_DEPTH));
    assign pop      = fifo_nonempty && bus.w_ready;
    assign push     = inflight[ROM_LATENCY-1];
    assign last_pop = (popped + LEN_W'(pop)) == length_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leave RUN on the cycle of the final pop so done lands right after it
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_pop) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = state == RUN;
        bus.done     = state == DONE;
        bus.rom_addr = rom_addr_q;
        bus.w_valid  = fifo_nonempty;
        bus.w_data   = fifo_nonempty ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            length_q   <= '0;
            issued     <= '0;
            popped     <= '0;
            rom_addr_q <= '0;
        end else if (accept) begin
            length_q   <= bus.length;
            issued     <= '0;
            popped     <= '0;
            rom_addr_q <= bus.base_addr;
        end else begin
            if (issue) begin
                issued     <= issued + 1'b1;
                rom_addr_q <= rom_addr_q + 1'b1;
            end
            if (pop) popped <= popped + 1'b1;
        end
    end

    // Credits cover FIFO occupancy plus reads still inside the ROM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits  <= '0;
            inflight <= '0;
        end else begin
            inflight <= ROM_LATENCY'({inflight, issue});
            if (issue && !pop) begin
                credits <= credits + 1'b1;
            end else if (!issue && pop) begin
                credits <= credits - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rom_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count == CW'(FIFO_DEPTH)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(pop && count == '0));

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credits <= CW'(FIFO_DEPTH));
endmodule
